// File: rtl/tutorial_aula_cpu_oci_dct_ctrl.sv
// tutorial_aula_cpu_oci_dct_ctrl
// Sequencer for the OCI data-capture-trace buffer. It packs ENTRY_W-bit trace
// entries into a DEPTH-entry shift buffer, with the newest entry at the LSBs.
// The packed word is drained to a valid/ready sink when any of these happens:
// the buffer fills, the idle timeout expires, or test_ending is raised.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   trc_valid/trc_data/trc_ready   trace entry input handshake
//   test_ending               level request for a final flush, then stop
//   out_valid/out_ready       packed word handshake to the sink
//   out_buffer/out_count      packed word and its number of valid entries
//   dct_buffer/dct_count      live view of the internal buffer and count
//   test_has_ended            sticky flag, set once the final drain is complete
//
// state | meaning
// FILL  | accepting entries, timeout timer running while count>0
// DRAIN | packed word presented on out_*, waiting for out_ready
// DONE  | final drain complete; everything frozen until reset
module tutorial_aula_cpu_oci_dct_ctrl #(
  parameter int ENTRY_W = 3,
  parameter int DEPTH   = 10,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     trc_valid,
  input  logic [ENTRY_W-1:0]       trc_data,
  output logic                     trc_ready,
  input  logic                     test_ending,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ENTRY_W*DEPTH-1:0] out_buffer,
  output logic [CNT_W-1:0]         out_count,
  output logic [ENTRY_W*DEPTH-1:0] dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic                     test_has_ended
);

  localparam int BUF_W = ENTRY_W * DEPTH;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [BUF_W-1:0]   buf_q;
  logic [CNT_W-1:0]   count_q;
  logic [TMR_W-1:0]   timer_q;
  logic               ending_q;

  logic               accept;
  logic               fills_up;
  logic               timeout_hit;
  logic [BUF_W-1:0]   buf_shift;
  logic [CNT_W-1:0]   count_inc;

  assign trc_ready  = (state == FILL);
  assign accept     = trc_valid & trc_ready;
  assign buf_shift  = {buf_q[BUF_W-ENTRY_W-1:0], trc_data};
  assign count_inc  = count_q + CNT_W'(1);
  assign fills_up   = (count_q == CNT_W'(DEPTH - 1));
  // The timer only ever counts while entries are pending, so the count
  // check here is purely defensive.
  assign timeout_hit = (TIMEOUT > 0) && (count_q != '0) &&
                       (timer_q == TMR_W'(TIMEOUT));

  // The output word is the internal buffer itself. It is frozen in DRAIN
  // because no accepts can happen there.
  assign out_buffer = buf_q;
  assign out_count  = count_q;
  assign dct_buffer = buf_q;
  assign dct_count  = count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= FILL;
      buf_q          <= '0;
      count_q        <= '0;
      timer_q        <= '0;
      ending_q       <= 1'b0;
      out_valid      <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (test_ending) ending_q <= 1'b1;

          if (accept) begin
            buf_q   <= buf_shift;
            count_q <= count_inc;
            timer_q <= '0;
          end else if ((TIMEOUT > 0) && (count_q != '0) && !timeout_hit) begin
            timer_q <= timer_q + TMR_W'(1);
          end

          // An accept restarts the idle window. So the timeout can only
          // fire on a cycle with no accept.
          if (accept && fills_up) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end else if (test_ending) begin
            if (accept || (count_q != '0)) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
            end else begin
              state          <= DONE;
              test_has_ended <= 1'b1;
            end
          end else if (!accept && timeout_hit) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end
        end

        DRAIN: begin
          if (test_ending) ending_q <= 1'b1;
          if (out_ready) begin
            buf_q     <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            out_valid <= 1'b0;
            // A test_ending that arrives on the handshake cycle itself
            // still counts as the final drain.
            if (ending_q || test_ending) begin
              state          <= DONE;
              test_has_ended <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end

        DONE: ;

        default: begin
          state     <= FILL;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
